// File: rtl/tone_sequencer.sv
// Queued note player: accepts pitch/octave/duration notes over valid/ready and plays each as a
// timed square wave, followed by a silent gap. Optional volume PWM gating is enabled by VOLUME_PWM_EN.
module tone_sequencer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DUR_W      = 16,
    parameter int GAP_MS     = 20,
    parameter int TONE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_note,
    input  logic [1:0]       in_octave,
    input  logic [DUR_W-1:0] in_dur,
    input  logic             abort,
`ifdef VOLUME_PWM_EN
    input  logic [2:0]       volume,
`endif
    output logic             speaker,
    output logic             busy,
    output logic             note_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int TICK = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK - 1);
    localparam logic [DUR_W-1:0] GAP_LEN   = DUR_W'(GAP_MS);
    localparam logic [DUR_W-1:0] MS_ONE    = DUR_W'(1);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0] ms_q, ms_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [31:0]      tone_q, tone_d;
    logic [31:0]      hp_q, hp_d;
    logic             pitched_q, pitched_d;
    logic             tone_ph_q, tone_ph_d;
    logic             speaker_q, speaker_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             note_done_q, note_done_d;

    logic [31:0] hp_tab, hp_sh, hp_sel;
    logic        xfer, tick;

    // abort wins over a same-cycle request, so it also masks ready
    assign in_ready  = ready_q & ~abort;
    assign xfer      = in_valid & in_ready;
    assign tick      = (presc_q == PRESC_MAX);
    assign speaker   = speaker_q;
    assign busy      = busy_q;
    assign note_done = note_done_q;

    always_comb begin
        case (in_note)
            4'd1:    hp_tab = 32'd381680;
            4'd2:    hp_tab = 32'd340136;
            4'd3:    hp_tab = 32'd303030;
            4'd4:    hp_tab = 32'd285714;
            4'd5:    hp_tab = 32'd255102;
            4'd6:    hp_tab = 32'd227273;
            4'd7:    hp_tab = 32'd202429;
            default: hp_tab = 32'd0;
        endcase
        hp_sh = hp_tab >> TONE_SHIFT;
        case (in_octave)
            2'b01:   hp_sel = hp_sh << 1;
            2'b10:   hp_sel = hp_sh >> 1;
            default: hp_sel = hp_sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        ms_d        = ms_q;
        dur_d       = dur_q;
        tone_d      = tone_q;
        hp_d        = hp_q;
        pitched_d   = pitched_q;
        tone_ph_d   = tone_ph_q;
        note_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d   = '0;
                ms_d      = '0;
                tone_d    = '0;
                tone_ph_d = 1'b0;
                if (xfer) begin
                    dur_d     = in_dur;
                    hp_d      = hp_sel;
                    pitched_d = (in_note >= 4'd1) && (in_note <= 4'd7);
                    if (in_dur != '0) state_d = ST_PLAY;
                    else              note_done_d = 1'b1;
                end
            end
            ST_PLAY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) ms_d = ms_q + MS_ONE;
                if (pitched_q) begin
                    if (tone_q + 32'd1 >= hp_q) begin
                        tone_d    = '0;
                        tone_ph_d = ~tone_ph_q;
                    end else begin
                        tone_d = tone_q + 32'd1;
                    end
                end
                // end of note overrides any toggle due in the same cycle
                if (tick && (ms_q + MS_ONE == dur_q)) begin
                    presc_d   = '0;
                    ms_d      = '0;
                    tone_d    = '0;
                    tone_ph_d = 1'b0;
                    if (GAP_MS == 0) begin
                        state_d     = ST_IDLE;
                        note_done_d = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) ms_d = ms_q + MS_ONE;
                if (tick && (ms_q + MS_ONE == GAP_LEN)) begin
                    state_d     = ST_IDLE;
                    presc_d     = '0;
                    ms_d        = '0;
                    note_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            ms_d        = '0;
            tone_d      = '0;
            tone_ph_d   = 1'b0;
            note_done_d = 1'b0;
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

`ifdef VOLUME_PWM_EN
    logic [2:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= pwm_q + 3'd1;
    end

    assign speaker_d = tone_ph_d & (pwm_q < volume);
`else
    assign speaker_d = tone_ph_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            ms_q        <= '0;
            dur_q       <= '0;
            tone_q      <= '0;
            hp_q        <= '0;
            pitched_q   <= 1'b0;
            tone_ph_q   <= 1'b0;
            speaker_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            note_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            dur_q       <= dur_d;
            tone_q      <= tone_d;
            hp_q        <= hp_d;
            pitched_q   <= pitched_d;
            tone_ph_q   <= tone_ph_d;
            speaker_q   <= speaker_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            note_done_q <= note_done_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 8 clk/ms, TONE_SHIFT=16 (do = 5 clk half-period), 2 ms gap.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_note;
    logic [1:0]  in_octave;
    logic [15:0] in_dur;
    logic        abort;
    logic        speaker;
    logic        busy;
    logic        note_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_sequencer #(
        .CLK_HZ    (8000),
        .DUR_W     (16),
        .GAP_MS    (2),
        .TONE_SHIFT(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_note  (in_note),
        .in_octave(in_octave),
        .in_dur   (in_dur),
        .abort    (abort),
        .speaker  (speaker),
        .busy     (busy),
        .note_done(note_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one note for one cycle; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] n, input logic [1:0] o, input logic [15:0] d);
        in_note   = n;
        in_octave = o;
        in_dur    = d;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({speaker, busy, in_ready, note_done} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_init spk/busy/rdy/done got %b want 0010",
                     {speaker, busy, in_ready, note_done});
        end
        rst_n = 1'b1;
        step();
        send(4'd1, 2'b00, 16'd4);
        repeat (7) step();
        checks++;
        if ({speaker, busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_play spk/busy got %b want 11", {speaker, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({speaker, busy, in_ready, note_done} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_async spk/busy/rdy/done got %b want 0010",
                     {speaker, busy, in_ready, note_done});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_tone();
        logic [3:0] exp_v;
        send(4'd1, 2'b00, 16'd4);
        for (int k = 0; k <= 49; k++) begin
            if (k > 0) step();
            exp_v[3] = (k < 32) ? ((k / 5) % 2 == 1) : 1'b0;
            exp_v[2] = (k < 48);
            exp_v[1] = (k == 48);
            exp_v[0] = !(k < 48);
            checks++;
            if ({speaker, busy, note_done, in_ready} !== exp_v) begin
                errors++;
                $display("FAIL tone k=%0d spk/busy/done/rdy got %b want %b",
                         k, {speaker, busy, note_done, in_ready}, exp_v);
            end
        end
    endtask

    task automatic test_octave();
        logic [1:0] octs [3];
        int         pers [3];
        logic [3:0] exp_v;
        octs = '{2'b01, 2'b10, 2'b11};
        pers = '{10, 2, 5};
        for (int i = 0; i < 3; i++) begin
            send(4'd1, octs[i], 16'd3);
            for (int k = 0; k <= 41; k++) begin
                if (k > 0) step();
                exp_v[3] = (k < 24) ? ((k / pers[i]) % 2 == 1) : 1'b0;
                exp_v[2] = (k < 40);
                exp_v[1] = (k == 40);
                exp_v[0] = !(k < 40);
                checks++;
                if ({speaker, busy, note_done, in_ready} !== exp_v) begin
                    errors++;
                    $display("FAIL octave oct=%b k=%0d spk/busy/done/rdy got %b want %b",
                             octs[i], k, {speaker, busy, note_done, in_ready}, exp_v);
                end
            end
        end
    endtask

    task automatic test_rest();
        logic [3:0] exp_v;
        send(4'd0, 2'b00, 16'd3);
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) step();
            exp_v = {1'b0, (k < 40), (k == 40), !(k < 40)};
            checks++;
            if ({speaker, busy, note_done, in_ready} !== exp_v) begin
                errors++;
                $display("FAIL rest k=%0d spk/busy/done/rdy got %b want %b",
                         k, {speaker, busy, note_done, in_ready}, exp_v);
            end
        end
    endtask

    task automatic test_zero_dur();
        send(4'd3, 2'b00, 16'd0);
        checks++;
        if ({speaker, busy, note_done, in_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL zero_dur_accept spk/busy/done/rdy got %b want 0011",
                     {speaker, busy, note_done, in_ready});
        end
        step();
        checks++;
        if ({speaker, busy, note_done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL zero_dur_after spk/busy/done/rdy got %b want 0001",
                     {speaker, busy, note_done, in_ready});
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_v;
        send(4'd1, 2'b00, 16'd4);
        repeat (9) step();
        checks++;
        if ({speaker, busy} !== 2'b11) begin
            errors++;
            $display("FAIL abort_pre spk/busy got %b want 11", {speaker, busy});
        end
        abort     = 1'b1;
        in_valid  = 1'b1;
        in_note   = 4'd1;
        in_octave = 2'b10;
        in_dur    = 16'd1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got %b want 0", in_ready);
        end
        step();
        abort = 1'b0;
        #1;
        checks++;
        if ({speaker, busy, note_done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_idle spk/busy/done/rdy got %b want 0001",
                     {speaker, busy, note_done, in_ready});
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) step();
            exp_v[3] = (k < 8) ? ((k / 2) % 2 == 1) : 1'b0;
            exp_v[2] = (k < 24);
            exp_v[1] = (k == 24);
            exp_v[0] = !(k < 24);
            checks++;
            if ({speaker, busy, note_done, in_ready} !== exp_v) begin
                errors++;
                $display("FAIL abort_next k=%0d spk/busy/done/rdy got %b want %b",
                         k, {speaker, busy, note_done, in_ready}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        logic       b;
        in_note   = 4'd1;
        in_octave = 2'b10;
        in_dur    = 16'd1;
        in_valid  = 1'b1;
        step();
        // second note (rest code 12) waits with valid held until the sequencer is free
        in_note   = 4'd12;
        in_octave = 2'b00;
        in_dur    = 16'd1;
        for (int k = 0; k <= 50; k++) begin
            if (k > 0) step();
            b = (k < 24) || (k >= 25 && k < 49);
            exp_v[3] = (k < 8) ? ((k / 2) % 2 == 1) : 1'b0;
            exp_v[2] = b;
            exp_v[1] = (k == 24) || (k == 49);
            exp_v[0] = !b;
            checks++;
            if ({speaker, busy, note_done, in_ready} !== exp_v) begin
                errors++;
                $display("FAIL b2b k=%0d spk/busy/done/rdy got %b want %b",
                         k, {speaker, busy, note_done, in_ready}, exp_v);
            end
            if (k == 25) in_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_note   = 4'd0;
        in_octave = 2'b00;
        in_dur    = 16'd0;
        abort     = 1'b0;
        step();
        step();
        test_reset();
        test_tone();
        test_octave();
        test_rest();
        test_zero_dur();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
